// File: rtl/adder_seg_pipe.sv
// Segmented pipelined unsigned adder (W/STAGES bits per stage); define LOA_EN for the lower-part OR approximation.
// Latency STAGES edges from accept to out_valid; the whole pipeline stalls together while the output is held.
module adder_seg_pipe #(
  parameter int W           = 8,
  parameter int STAGES      = 2,
  parameter int CNT_W       = 16,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  output logic [CNT_W-1:0] txn_count
);

  localparam int SW = W / STAGES;

  logic [STAGES-1:0]        vld_q, vld_d, cy_q, cy_d;
  logic [STAGES-1:0][W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     advance;
  logic [SW:0]              s0, sk;

`ifdef LOA_EN
  localparam int LMASK = (1 << APPROX_BITS) - 1;
  logic [SW-1:0] lmask;
  logic          loa_c;

  assign lmask = SW'(LMASK);

  // Carry injected above the OR-ed lower part comes from its top bit pair only.
  if (APPROX_BITS > 0) begin : g_loa_c
    assign loa_c = a[APPROX_BITS-1] & b[APPROX_BITS-1];
  end else begin : g_no_loa_c
    assign loa_c = 1'b0;
  end
`endif

  always_comb begin
    advance = ~vld_q[STAGES-1] | out_ready;
    vld_d   = vld_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q + CNT_W'(vld_q[STAGES-1] & out_ready);
    sk      = '0;

`ifdef LOA_EN
    s0 = ({1'b0, a[SW-1:0] & ~lmask} + {1'b0, b[SW-1:0] & ~lmask})
       + ({{SW{1'b0}}, loa_c} << APPROX_BITS);
    s0[SW-1:0] = s0[SW-1:0] | ((a[SW-1:0] | b[SW-1:0]) & lmask);
`else
    s0 = {1'b0, a[SW-1:0]} + {1'b0, b[SW-1:0]};
`endif

    if (advance) begin
      vld_d[0]          = in_valid;
      a_d[0]            = a;
      b_d[0]            = b;
      cy_d[0]           = s0[SW];
      res_d[0]          = '0;
      res_d[0][SW-1:0]  = s0[SW-1:0];
      // Each later stage consumes its own segment and carries finished low bits forward.
      for (int k = 1; k < STAGES; k++) begin
        sk = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]}
           + {{SW{1'b0}}, cy_q[k-1]};
        vld_d[k]             = vld_q[k-1];
        a_d[k]               = a_q[k-1];
        b_d[k]               = b_q[k-1];
        cy_d[k]              = sk[SW];
        res_d[k]             = res_q[k-1];
        res_d[k][k*SW +: SW] = sk[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  // Already-consumed operand segments are carried for alignment only.
  logic unused_ops;
  assign unused_ops = ^{a_q, b_q};

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = {cy_q[STAGES-1], res_q[STAGES-1]};
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_adder_seg_pipe.sv
// Bench for adder_seg_pipe: three configurations checked against a whole-pipeline reference model.
module tb_adder_seg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // W=8, STAGES=4, CNT_W=4
  logic       iv, ir, ov, ordy;
  logic [7:0] a, b;
  logic [8:0] s;
  logic [3:0] tc;
  // W=2, STAGES=1
  logic        iv2, ir2, ov2, ordy2;
  logic [1:0]  a2, b2;
  logic [2:0]  s2;
  logic [15:0] tc2;
  // W=4, STAGES=2
  logic        iv3, ir3, ov3, ordy3;
  logic [3:0]  a3, b3;
  logic [4:0]  s3;
  logic [15:0] tc3;

  adder_seg_pipe #(.W(8), .STAGES(4), .CNT_W(4), .APPROX_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy), .sum(s), .txn_count(tc));

  adder_seg_pipe #(.W(2), .STAGES(1), .CNT_W(16), .APPROX_BITS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(ordy2), .sum(s2), .txn_count(tc2));

  adder_seg_pipe #(.W(4), .STAGES(2), .CNT_W(16), .APPROX_BITS(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .out_valid(ov3), .out_ready(ordy3), .sum(s3), .txn_count(tc3));

  int checks = 0;
  int failures = 0;

  // Reference: STAGES slots of (valid, sum) that shift together whenever the pipeline may advance.
  logic       mv [4];
  logic [8:0] ms [4];
  int         mcnt;

  function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y);
`ifdef LOA_EN
    int lo;
    int c;
    lo = (int'(x) | int'(y)) & 3;
    c  = int'(x[1] & y[1]);
    return 9'((((int'(x) >> 2) + (int'(y) >> 2) + c) * 4) + lo);
`else
    return 9'(int'(x) + int'(y));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      ms[k] = '0;
    end
    mcnt = 0;
  endtask

  // Called at a falling edge; drives one cycle of dut stimulus and checks it.
  task automatic cyc(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic r);
    iv = v; a = aa; b = bb; ordy = r;
    #1;
    chk("out_valid", 32'(ov), 32'(mv[3]));
    if (mv[3]) chk("sum", 32'(s), 32'(ms[3]));
    chk("in_ready", 32'(ir), 32'(!mv[3] || r));
    chk("txn_count", 32'(tc), 32'(mcnt % 16));
    @(posedge clk);
    if (mv[3] && r) mcnt++;
    if (!mv[3] || r) begin
      for (int k = 3; k > 0; k--) begin
        mv[k] = mv[k-1];
        ms[k] = ms[k-1];
      end
      mv[0] = v;
      ms[0] = ref_sum(aa, bb);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 0; a = 0; b = 0; ordy = 1;
    iv2 = 0; a2 = 0; b2 = 0; ordy2 = 1;
    iv3 = 0; a3 = 0; b3 = 0; ordy3 = 1;
    clear_model();
    #2;
    chk("rst_out_valid", 32'(ov), 0);
    chk("rst_sum", 32'(s), 0);
    chk("rst_txn", 32'(tc), 0);
    chk("rst_out_valid2", 32'(ov2), 0);
    chk("rst_sum3", 32'(s3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // W=4, STAGES=2 latency and carry-out
    iv3 = 1; a3 = 4'hF; b3 = 4'h1;
    @(posedge clk); @(negedge clk);
    chk("w4_early_valid", 32'(ov3), 0);
    a3 = 4'h7; b3 = 4'h8;
    @(posedge clk); @(negedge clk);
    iv3 = 0;
    chk("w4_valid0", 32'(ov3), 1);
    chk("w4_sum0", 32'(s3), 32'h10);
    @(posedge clk); @(negedge clk);
    chk("w4_valid1", 32'(ov3), 1);
    chk("w4_sum1", 32'(s3), 32'h0F);
    @(posedge clk); @(negedge clk);
    chk("w4_idle", 32'(ov3), 0);
    chk("w4_txn", 32'(tc3), 2);

    // W=2, STAGES=1 exhaustive, back to back
    for (int i = 0; i < 16; i++) begin
      iv2 = 1; a2 = 2'(i >> 2); b2 = 2'(i & 3);
      @(posedge clk); @(negedge clk);
      chk("w2_valid", 32'(ov2), 1);
      chk("w2_sum", 32'(s2), 32'((i >> 2) + (i & 3)));
      chk("w2_in_ready", 32'(ir2), 1);
    end
    iv2 = 0;
    @(posedge clk); @(negedge clk);
    chk("w2_txn", 32'(tc2), 16);
    chk("w2_idle", 32'(ov2), 0);

    // Main config: random traffic with random backpressure
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    // Six inputs offered into a five-cycle stall
    for (int i = 0; i < 9; i++)
      cyc(i < 6, 8'($urandom), 8'($urandom), !(i >= 2 && i < 7));
    cyc(1, 8'h03, 8'h01, 1);
    cyc(1, 8'h02, 8'h02, 1);
    cyc(1, 8'hFF, 8'hFF, 1);
    cyc(1, 8'hFF, 8'h01, 1);
    for (int i = 0; i < 20; i++)
      cyc(1, 8'($urandom), 8'($urandom), 1);
    for (int i = 0; i < 6; i++)
      cyc(0, 8'h00, 8'h00, 1);

    // Reset with transactions in flight and the output holding
    for (int i = 0; i < 5; i++)
      cyc(1, 8'($urandom_range(1, 255)), 8'($urandom), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov), 0);
    chk("midrst_sum", 32'(s), 0);
    chk("midrst_txn", 32'(tc), 0);
    clear_model();
    iv = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc(0, 8'($urandom), 8'($urandom), 1);
    for (int i = 0; i < 12; i++)
      cyc(1, 8'($urandom), 8'($urandom), $urandom_range(0, 1) != 0);
    for (int i = 0; i < 8; i++)
      cyc(0, 8'h00, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
